// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: shared icache event structs and performance counter map
package snitch_icache_pkg;

    typedef struct packed {
        logic l0_miss;
        logic l0_hit;
        logic l0_prefetch;
        logic l0_double_hit;
        logic l0_stall;
    } icache_l0_events_t;

    typedef struct packed {
        logic l1_miss;
        logic l1_hit;
        logic l1_stall;
        logic l1_handler_stall;
        logic l1_tag_parity_error;
        logic l1_data_parity_error;
    } icache_l1_events_t;

    localparam int unsigned PERF_NUM_CNT = 12;
    localparam int unsigned PERF_CNT_W   = 32;

    typedef enum logic [3:0] {
        PerfL0Miss         = 4'd0,
        PerfL0Hit          = 4'd1,
        PerfL0Prefetch     = 4'd2,
        PerfL0DoubleHit    = 4'd3,
        PerfL0Stall        = 4'd4,
        PerfL1Miss         = 4'd5,
        PerfL1Hit          = 4'd6,
        PerfL1Stall        = 4'd7,
        PerfL1HandlerStall = 4'd8,
        PerfL1TagParity    = 4'd9,
        PerfL1DataParity   = 4'd10,
        PerfCycles         = 4'd11
    } perf_cnt_idx_e;

endpackage

// File: rtl/snitch_icache_perf_cnt.sv
// snitch_icache_perf_cnt: single event counter with clear/read-clear; saturates when SNITCH_ICACHE_PERF_SATURATE_EN is defined, wraps otherwise
module snitch_icache_perf_cnt
    import snitch_icache_pkg::*;
#(
    parameter int unsigned CNT_W = PERF_CNT_W,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             rd_clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d, inc, nxt;

    assign inc = CNT_W'(inc_i);

`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
    logic [CNT_W:0] sum;
    assign sum = {1'b0, cnt_q} + {1'b0, inc};
    assign nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    assign nxt = cnt_q + inc;
`endif

    // global clear beats read-and-clear, which keeps only this cycle's increment
    always_comb begin
        cnt_d = clr_i ? '0 : rd_clr_i ? (en_i ? inc : '0) : en_i ? nxt : cnt_q;
    end

    // counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snitch_icache_perf_cnt_bank.sv
// snitch_icache_perf_cnt_bank: bank of icache event counters with a 1-cycle read port; SNITCH_ICACHE_PERF_SATURATE_EN selects saturating counters
module snitch_icache_perf_cnt_bank
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_W          = PERF_CNT_W,
    parameter int unsigned DATA_W         = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   en_i,
    input  logic                                   clear_i,
    input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
    input  icache_l1_events_t                      l1_events_i,
    input  logic                                   rd_req_i,
    input  logic [3:0]                             rd_addr_i,
    input  logic                                   rd_clr_i,
    output logic                                   rd_rvalid_o,
    output logic [DATA_W-1:0]                      rd_rdata_o,
    output logic                                   rd_err_o
);

    localparam int unsigned INC_W = $clog2(NR_FETCH_PORTS + 1);

    logic [PERF_NUM_CNT-1:0][INC_W-1:0] inc;
    logic [PERF_NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]                   sel;
    logic [DATA_W-1:0]                  rdata_d, rdata_q;
    logic                               err_d, err_q, rvalid_q;

    // L0 increments are popcounts across fetch ports; L1 and cycle increments are single bits
    always_comb begin
        inc = '0;
        for (int p = 0; p < int'(NR_FETCH_PORTS); p++) begin
            inc[PerfL0Miss]      = inc[PerfL0Miss]      + INC_W'(l0_events_i[p].l0_miss);
            inc[PerfL0Hit]       = inc[PerfL0Hit]       + INC_W'(l0_events_i[p].l0_hit);
            inc[PerfL0Prefetch]  = inc[PerfL0Prefetch]  + INC_W'(l0_events_i[p].l0_prefetch);
            inc[PerfL0DoubleHit] = inc[PerfL0DoubleHit] + INC_W'(l0_events_i[p].l0_double_hit);
            inc[PerfL0Stall]     = inc[PerfL0Stall]     + INC_W'(l0_events_i[p].l0_stall);
        end
        inc[PerfL1Miss]         = INC_W'(l1_events_i.l1_miss);
        inc[PerfL1Hit]          = INC_W'(l1_events_i.l1_hit);
        inc[PerfL1Stall]        = INC_W'(l1_events_i.l1_stall);
        inc[PerfL1HandlerStall] = INC_W'(l1_events_i.l1_handler_stall);
        inc[PerfL1TagParity]    = INC_W'(l1_events_i.l1_tag_parity_error);
        inc[PerfL1DataParity]   = INC_W'(l1_events_i.l1_data_parity_error);
        inc[PerfCycles]         = INC_W'(1'b1);
    end

    for (genvar c = 0; c < int'(PERF_NUM_CNT); c++) begin : g_cnt
        snitch_icache_perf_cnt #(
            .CNT_W (CNT_W),
            .INC_W (INC_W)
        ) i_cnt (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (en_i),
            .clr_i    (clear_i),
            .rd_clr_i (rd_req_i & rd_clr_i & (rd_addr_i == 4'(c))),
            .inc_i    (inc[c]),
            .cnt_o    (cnt[c])
        );
    end

    // read mux; out-of-range addresses select zero
    always_comb begin
        sel   = '0;
        err_d = rd_addr_i >= 4'(PERF_NUM_CNT);
        for (int c = 0; c < int'(PERF_NUM_CNT); c++) sel = (rd_addr_i == 4'(c)) ? cnt[c] : sel;
    end

    if (CNT_W >= DATA_W) begin : g_trunc
        assign rdata_d = sel[DATA_W-1:0];
    end else begin : g_zext
        assign rdata_d = {{(DATA_W - CNT_W){1'b0}}, sel};
    end

    // response registers, data held between requests
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_req_i;
            if (rd_req_i) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // outputs read as zero while reset is asserted, dropping any pending response
    assign rd_rvalid_o = rvalid_q & ~rst_i;
    assign rd_rdata_o  = rst_i ? '0 : rdata_q;
    assign rd_err_o    = err_q & ~rst_i;

endmodule

// File: tb/tb_snitch_icache_perf_cnt_bank.sv
// tb_snitch_icache_perf_cnt_bank: directed and random checks of the counter bank against a behavioural model
module tb_snitch_icache_perf_cnt_bank;
    import snitch_icache_pkg::*;

    localparam int NR  = 2;
    localparam int CW  = 8;
    localparam int DW  = 32;
    localparam int NC  = 12;
    localparam int L0W = NR * $bits(icache_l0_events_t);
    localparam int L1W = $bits(icache_l1_events_t);
    localparam longint MAXV = (64'd1 << CW) - 1;
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
    localparam longint OVF1 = 255;
    localparam longint OVF2 = 255;
`else
    localparam longint OVF1 = 0;
    localparam longint OVF2 = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, clr = 1'b0, req = 1'b0, rclr = 1'b0;
    logic [3:0] addr = '0;
    icache_l0_events_t [NR-1:0] l0 = '0;
    icache_l1_events_t l1 = '0;
    logic rvalid, err;
    logic [DW-1:0] rdata;

    longint m [NC];
    logic hv = 1'b0, he = 1'b0;
    longint hd = 0;
    bit go = 1'b0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    snitch_icache_perf_cnt_bank #(
        .NR_FETCH_PORTS (NR),
        .CNT_W          (CW),
        .DATA_W         (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .clear_i     (clr),
        .l0_events_i (l0),
        .l1_events_i (l1),
        .rd_req_i    (req),
        .rd_addr_i   (addr),
        .rd_clr_i    (rclr),
        .rd_rvalid_o (rvalid),
        .rd_rdata_o  (rdata),
        .rd_err_o    (err)
    );

    function automatic longint add(longint a, longint b);
        longint s = a + b;
`ifdef SNITCH_ICACHE_PERF_SATURATE_EN
        return (s > MAXV) ? MAXV : s;
`else
        return s & MAXV;
`endif
    endfunction

    function automatic longint incr(int c);
        longint n = 0;
        if (c < 5) begin
            for (int p = 0; p < NR; p++) n += longint'(l0[p][4-c]);
        end else if (c < 11) begin
            n = longint'(l1[10-c]);
        end else begin
            n = 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        longint nx [NC];
        if (rst) begin
            for (int c = 0; c < NC; c++) m[c] = 0;
            hv = 1'b0; hd = 0; he = 1'b0;
        end else begin
            hv = req;
            if (req) begin
                he = (addr >= 4'(NC));
                hd = he ? 0 : m[addr];
            end
            for (int c = 0; c < NC; c++) begin
                if (clr) nx[c] = 0;
                else if (req && rclr && int'(addr) == c) nx[c] = en ? incr(c) : 0;
                else if (en) nx[c] = add(m[c], incr(c));
                else nx[c] = m[c];
            end
            for (int c = 0; c < NC; c++) m[c] = nx[c];
        end
        go = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic c, input longint exp, input string nm);
        req = 1'b1; addr = a; rclr = c;
        cyc();
        req = 1'b0; rclr = 1'b0;
        chk({nm, "_valid"}, 64'(rvalid), 64'd1);
        chk({nm, "_data"}, 64'(rdata), 64'(exp));
        chk({nm, "_err"}, 64'(err), (a >= 4'(NC)) ? 64'd1 : 64'd0);
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("cyc_rvalid", 64'(rvalid), rst ? 64'd0 : 64'(hv));
            chk("cyc_rdata", 64'(rdata), rst ? 64'd0 : 64'(hd));
            chk("cyc_err", 64'(err), rst ? 64'd0 : 64'(he));
        end
    end

    initial begin
        logic [L0W-1:0] r0;
        logic [L1W-1:0] r1;
        cyc();
        cyc();
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0; en = 1'b1;
        l0[0].l0_hit = 1'b1; l0[1].l0_hit = 1'b1;
        repeat (10) cyc();
        l0 = '0;
        rd(4'd1, 1'b0, 20, "l0_hit");
        clr = 1'b1; cyc(); clr = 1'b0;
        l1.l1_miss = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en = (i != 1 && i != 3);
            cyc();
        end
        l1 = '0; en = 1'b1;
        rd(4'd5, 1'b0, 3, "l1_miss");
        rd(4'd11, 1'b0, 4, "cycles");
        clr = 1'b1; cyc(); clr = 1'b0;
        l1.l1_hit = 1'b1;
        repeat (7) cyc();
        rd(4'd6, 1'b1, 7, "rdclr");
        l1 = '0;
        rd(4'd6, 1'b0, 1, "rdclr_after");
        clr = 1'b1; cyc(); clr = 1'b0;
        l0[0].l0_stall = 1'b1; l0[1].l0_stall = 1'b1;
        repeat (4) cyc();
        l0[1].l0_stall = 1'b0;
        cyc();
        l0[1].l0_stall = 1'b1; clr = 1'b1;
        rd(4'd4, 1'b0, 9, "clr_vs_rd");
        clr = 1'b0; l0 = '0;
        rd(4'd4, 1'b0, 0, "after_clr");
        rd(4'd13, 1'b1, 0, "bad_addr");
        clr = 1'b1; cyc(); clr = 1'b0;
        l0[0].l0_miss = 1'b1; l0[1].l0_miss = 1'b1;
        repeat (127) cyc();
        l0 = '0;
        rd(4'd0, 1'b0, 254, "pre_ovf");
        l0[0].l0_miss = 1'b1; l0[1].l0_miss = 1'b1;
        cyc();
        l0 = '0;
        rd(4'd0, 1'b0, OVF1, "ovf");
        l0[0].l0_miss = 1'b1; l0[1].l0_miss = 1'b1;
        cyc();
        l0 = '0;
        rd(4'd0, 1'b0, OVF2, "ovf_next");
        req = 1'b1; addr = 4'd0; cyc();
        req = 1'b0; rst = 1'b1; cyc();
        rst = 1'b0;
        repeat (3000) begin
            rst  = ($urandom_range(0, 199) == 0);
            clr  = ($urandom_range(0, 29) == 0);
            en   = ($urandom_range(0, 7) != 0);
            req  = $urandom_range(0, 1) == 1;
            addr = 4'($urandom_range(0, 15));
            rclr = ($urandom_range(0, 3) == 0);
            r0 = L0W'($urandom);
            r1 = L1W'($urandom);
            l0 = r0;
            l1 = r1;
            cyc();
        end
        rst = 1'b0; req = 1'b0; clr = 1'b0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
